// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: state encoding, data widths,
// the canonical NOP encoding and the byte-to-word address shift.
package fetch_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned WORD_SHIFT = 2;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready slot: fetch drives the master side,
// the decoder the slave side.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport master (output out_valid, output out_pc, output out_instr, input  out_ready);
  modport slave  (input  out_valid, input  out_pc, input  out_instr, output out_ready);
endinterface

// File: rtl/fetch_unit_pc_check.sv
// Combinational fetch-target checker: flags byte addresses that are not
// word aligned or whose word index falls outside the instruction memory.
module fetch_pc_check
  import fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic [XLEN-1:0] addr,
  output logic            fault
);

  logic [XLEN-1:0] word_idx;

  assign word_idx = addr >> WORD_SHIFT;
  assign fault    = (addr[WORD_SHIFT-1:0] != '0) || (word_idx >= XLEN'(IMEM_DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers one fetched instruction for
// decode, handles redirects and traps on bad targets. Optional FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_DEPTH = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  fetch_unit_if.master       dec,
  output logic               fetch_err,
  output logic [XLEN-1:0]    err_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_redirects
`endif
);

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    out_pc_q, out_pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic               fetch_err_q, fetch_err_d;
  logic [XLEN-1:0]    err_pc_q, err_pc_d;
  logic [XLEN-1:0]    pc_plus4;
  logic               redir_fault, seq_fault;
  logic               load;

  assign pc_plus4 = pc_q + XLEN'(4);

  fetch_pc_check #(.IMEM_DEPTH(IMEM_DEPTH)) u_redir_check (.addr(redirect_pc), .fault(redir_fault));
  fetch_pc_check #(.IMEM_DEPTH(IMEM_DEPTH)) u_seq_check   (.addr(pc_plus4),    .fault(seq_fault));

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    fetch_err_d = fetch_err_q;
    err_pc_d    = err_pc_q;
    load        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          if (redir_fault) begin
            state_d     = ST_TRAP;
            fetch_err_d = 1'b1;
            err_pc_d    = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (fetch_en) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          if (redir_fault) begin
            state_d     = ST_TRAP;
            fetch_err_d = 1'b1;
            err_pc_d    = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (!out_valid_q || dec.out_ready) begin
          if (fetch_en) begin
            load        = 1'b1;
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = imem_instr;
            // The last in-range word is still delivered; only the PC advance traps.
            if (seq_fault) begin
              state_d     = ST_TRAP;
              fetch_err_d = 1'b1;
              err_pc_d    = pc_plus4;
            end else begin
              pc_d = pc_plus4;
            end
          end else begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_TRAP: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          if (redir_fault) begin
            err_pc_d = redirect_pc;
          end else begin
            pc_d        = redirect_pc;
            fetch_err_d = 1'b0;
            state_d     = ST_RUN;
          end
        end else if (dec.out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      fetch_err_q <= 1'b0;
      err_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      fetch_err_q <= fetch_err_d;
      err_pc_q    <= err_pc_d;
    end
  end

  assign imem_addr     = {{WORD_SHIFT{1'b0}}, pc_q[XLEN-1:WORD_SHIFT]};
  assign dec.out_valid = out_valid_q;
  assign dec.out_pc    = out_pc_q;
  assign dec.out_instr = out_instr_q;
  assign fetch_err     = fetch_err_q;
  assign err_pc        = err_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q;
    perf_redirects_d = perf_redirects_q;
    if (state_q != ST_TRAP) begin
      if (load)           perf_fetched_d   = perf_fetched_q + 32'd1;
      if (redirect_valid) perf_redirects_d = perf_redirects_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: a 1024-word instance driven from a
// vector table, plus a 4-word instance for the sequential end-of-memory trap.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    logic        en;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        eerr;
    logic [31:0] eerrpc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        fetch_en, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_instr, err_pc;
  logic        fetch_err;

  logic        fetch_en2, redirect_valid2;
  logic [31:0] redirect_pc2, imem_addr2, imem_instr2, err_pc2;
  logic        fetch_err2;

  int n_vec = 0;
  int n_bad = 0;

  fetch_unit_if dec1 ();
  fetch_unit_if dec2 ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_redirects, perf_fetched2, perf_redirects2;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] word);
    return {16'hC0DE, word[15:0]};
  endfunction

  assign imem_instr  = instr_of(imem_addr);
  assign imem_instr2 = instr_of(imem_addr2);

  fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .dec(dec1), .fetch_err(fetch_err), .err_pc(err_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`endif
  );

  fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .dec(dec2), .fetch_err(fetch_err2), .err_pc(err_pc2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched2), .perf_redirects(perf_redirects2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] eaddr, input logic eerr,
                              input logic [31:0] eerrpc);
    vec_t v;
    v.en = en; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
    v.epc = epc; v.eaddr = eaddr; v.eerr = eerr; v.eerrpc = eerrpc;
    return v;
  endfunction

  vec_t vecs[26];

  logic [31:0] got_pc[8];
  logic [31:0] got_instr[8];
  int          n_got;

  initial begin
    //            en rv rpc           rdy ev pc           addr         err errpc
    vecs[0]  = mk(1, 0, 32'h0,        1,  0, 32'h0,       32'h0,       0, 32'h0);
    vecs[1]  = mk(1, 0, 32'h0,        1,  1, 32'h0,       32'h1,       0, 32'h0);
    vecs[2]  = mk(1, 0, 32'h0,        1,  1, 32'h4,       32'h2,       0, 32'h0);
    vecs[3]  = mk(1, 0, 32'h0,        1,  1, 32'h8,       32'h3,       0, 32'h0);
    vecs[4]  = mk(1, 0, 32'h0,        0,  1, 32'h8,       32'h3,       0, 32'h0);
    vecs[5]  = mk(1, 0, 32'h0,        0,  1, 32'h8,       32'h3,       0, 32'h0);
    vecs[6]  = mk(1, 0, 32'h0,        0,  1, 32'h8,       32'h3,       0, 32'h0);
    vecs[7]  = mk(1, 0, 32'h0,        1,  1, 32'hC,       32'h4,       0, 32'h0);
    vecs[8]  = mk(1, 0, 32'h0,        1,  1, 32'h10,      32'h5,       0, 32'h0);
    vecs[9]  = mk(1, 1, 32'h40,       0,  0, 32'h0,       32'h10,      0, 32'h0);
    vecs[10] = mk(1, 0, 32'h0,        0,  1, 32'h40,      32'h11,      0, 32'h0);
    vecs[11] = mk(1, 0, 32'h0,        1,  1, 32'h44,      32'h12,      0, 32'h0);
    vecs[12] = mk(1, 1, 32'h42,       1,  0, 32'h0,       32'h12,      1, 32'h42);
    vecs[13] = mk(1, 0, 32'h0,        1,  0, 32'h0,       32'h12,      1, 32'h42);
    vecs[14] = mk(1, 1, 32'h1000,     1,  0, 32'h0,       32'h12,      1, 32'h1000);
    vecs[15] = mk(1, 1, 32'h80,       1,  0, 32'h0,       32'h20,      0, 32'h1000);
    vecs[16] = mk(1, 0, 32'h0,        1,  1, 32'h80,      32'h21,      0, 32'h1000);
    vecs[17] = mk(0, 0, 32'h0,        0,  1, 32'h80,      32'h21,      0, 32'h1000);
    vecs[18] = mk(0, 0, 32'h0,        1,  0, 32'h0,       32'h21,      0, 32'h1000);
    vecs[19] = mk(0, 0, 32'h0,        1,  0, 32'h0,       32'h21,      0, 32'h1000);
    vecs[20] = mk(0, 1, 32'h200,      1,  0, 32'h0,       32'h80,      0, 32'h1000);
    vecs[21] = mk(0, 0, 32'h0,        1,  0, 32'h0,       32'h80,      0, 32'h1000);
    vecs[22] = mk(1, 0, 32'h0,        1,  0, 32'h0,       32'h80,      0, 32'h1000);
    vecs[23] = mk(1, 0, 32'h0,        1,  1, 32'h200,     32'h81,      0, 32'h1000);
    vecs[24] = mk(1, 1, 32'h300,      1,  0, 32'h0,       32'hC0,      0, 32'h1000);
    vecs[25] = mk(1, 0, 32'h0,        1,  1, 32'h300,     32'hC1,      0, 32'h1000);

    rst_n = 1'b0;
    fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec1.out_ready = 1'b0;
    fetch_en2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0; dec2.out_ready = 1'b0;

    #12;
    check("rst.valid",  32'(dec1.out_valid), 32'h0);
    check("rst.pc",     dec1.out_pc,         32'h0);
    check("rst.instr",  dec1.out_instr,      32'h0);
    check("rst.err",    32'(fetch_err),      32'h0);
    check("rst.err_pc", err_pc,              32'h0);
    check("rst.addr",   imem_addr,           32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      fetch_en       = vecs[i].en;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      dec1.out_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.valid", i),  32'(dec1.out_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d.addr", i),   imem_addr,           vecs[i].eaddr);
      check($sformatf("v%0d.err", i),    32'(fetch_err),      32'(vecs[i].eerr));
      check($sformatf("v%0d.err_pc", i), err_pc,              vecs[i].eerrpc);
      if (vecs[i].ev) begin
        check($sformatf("v%0d.pc", i),    dec1.out_pc,    vecs[i].epc);
        check($sformatf("v%0d.instr", i), dec1.out_instr, instr_of(vecs[i].epc >> 2));
      end
    end

    // Asynchronous reset with a live slot, sampled before the next clock edge.
    fetch_en = 1'b0; redirect_valid = 1'b0; dec1.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid",  32'(dec1.out_valid), 32'h0);
    check("arst.addr",   imem_addr,           32'h0);
    check("arst.err_pc", err_pc,              32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("arst.perf_fetched",   perf_fetched,   32'h0);
    check("arst.perf_redirects", perf_redirects, 32'h0);
`endif
    #2;
    rst_n = 1'b1;

    // Sequential run off the end of a 4-word memory.
    fetch_en2 = 1'b1;
    dec2.out_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (dec2.out_valid && n_got < 8) begin
        got_pc[n_got]    = dec2.out_pc;
        got_instr[n_got] = dec2.out_instr;
        n_got++;
      end
    end
    check("end.delivered", 32'(n_got), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_got) begin
        check($sformatf("end.pc%0d", k),    got_pc[k],    32'(4 * k));
        check($sformatf("end.instr%0d", k), got_instr[k], instr_of(32'(k)));
      end
    end
    check("end.err",    32'(fetch_err2),     32'h1);
    check("end.err_pc", err_pc2,             32'h10);
    check("end.valid",  32'(dec2.out_valid), 32'h0);
    check("end.addr",   imem_addr2,          32'h3);
`ifdef FETCH_PERF_CNT_EN
    check("end.perf_fetched",   perf_fetched2,   32'd4);
    check("end.perf_redirects", perf_redirects2, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
